config_loader: RTL and testbench

Configuration-side driver for the block-style config latches in every SLICEL. It accepts a word-serial bitstream over a valid/ready handshake and packs it into MEM_SIZE-bit frames. It presents each frame on a shared config bus and strobes a one-hot enable to each target block in order: block 0, then block 1, and so on. It sits between the fabric's bitstream source and the config_in/cen inputs of NUM_BLOCKS latch blocks.

---
 rtl/config_loader_pkg.sv | 28 ++
 rtl/config_word_packer.sv | 73 +++++++
 rtl/config_loader.sv | 143 ++++++++++++++
 tb/tb_config_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
//
// Shared types and helper functions for the configuration loader.
//   state_t    - loader FSM states
//   calc_wpf   - words per frame (frame width / word width)
//   calc_idx_w - counter width for an index range, at least one bit
// -----------------------------------------------------------------------------
package config_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic int calc_wpf(input int mem_size, input int word_bits);
        return mem_size / word_bits;
    endfunction

    // A single-entry range still needs a one-bit counter so that every
    // counter has a legal, non-zero width.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/config_word_packer.sv
// -----------------------------------------------------------------------------
// config_word_packer
//
// Assembles consecutive bitstream words into one frame. The first word
// lands in the LSBs.
//
// Ports:
//   cclk, rst_n  - configuration clock, asynchronous active-low reset
//   word_in      - incoming bitstream word
//   accept       - word_in is consumed on this edge
//   clear        - discard any partial frame and restart at word 0
//   frame_full   - this accept completes the frame (combinational)
//   frame_out    - frame including the word being accepted this cycle
// -----------------------------------------------------------------------------
module config_word_packer
    import config_loader_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int MEM_SIZE  = 16
) (
    input  logic                 cclk,
    input  logic                 rst_n,
    input  logic [WORD_BITS-1:0] word_in,
    input  logic                 accept,
    input  logic                 clear,
    output logic                 frame_full,
    output logic [MEM_SIZE-1:0]  frame_out
);

    localparam int WPF   = calc_wpf(MEM_SIZE, WORD_BITS);
    localparam int CNT_W = calc_idx_w(WPF);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPF - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_SIZE-1:0] asm_q, asm_d;

    // frame_out is the next-state value so that the top level can commit the
    // complete frame on the same edge the last word is accepted.
    always_comb begin
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        frame_full = 1'b0;
        if (clear) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            for (int k = 0; k < WPF; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    asm_d[k*WORD_BITS +: WORD_BITS] = word_in;
                end
            end
            if (cnt_q == LAST_WORD) begin
                frame_full = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign frame_out = asm_d;

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Loads NUM_BLOCKS config latch blocks from a word-serial bitstream. Each
// frame of MEM_SIZE bits is presented on config_out and strobed into one
// block with a single-cycle one-hot cen pulse, block 0 first.
//
// Ports:
//   cclk, rst_n  - configuration clock, asynchronous active-low reset
//   start        - begin a load pass (only honoured in IDLE)
//   abort        - cancel the current pass
//   in_data      - bitstream word
//   in_valid     - in_data is valid
//   in_ready     - loader accepts a word this cycle
//   config_out   - committed frame, shared by every latch block
//   cen          - one-hot latch enable, registered
//   busy         - pass in progress
//   done         - last pass finished without abort
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_BITS  = 8,
    parameter int MEM_SIZE   = 16,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_BITS-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic [NUM_BLOCKS-1:0] cen,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = calc_idx_w(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(NUM_BLOCKS - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      blk_q, blk_d;
    logic [MEM_SIZE-1:0]   config_q, config_d;
    logic [NUM_BLOCKS-1:0] cen_q, cen_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  pack_clear;
    logic                  frame_full;
    logic [MEM_SIZE-1:0]   frame;

    assign in_ready   = (state_q == LOAD);
    assign accept     = in_valid & in_ready;
    assign busy       = (state_q != IDLE);
    assign config_out = config_q;
    assign cen        = cen_q;
    assign done       = done_q;

    // The packer restarts at word 0 when a pass begins, when a pass is
    // aborted (discarding the partial frame) and before each new frame.
    // Kept outside the FSM process so frame_full has no apparent loop back.
    assign pack_clear = ((state_q == IDLE) && start)
                     || ((state_q != IDLE) && abort)
                     || ((state_q == HOLD) && (blk_q != LAST_BLK));

    config_word_packer #(
        .WORD_BITS (WORD_BITS),
        .MEM_SIZE  (MEM_SIZE)
    ) u_packer (
        .cclk       (cclk),
        .rst_n      (rst_n),
        .word_in    (in_data),
        .accept     (accept),
        .clear      (pack_clear),
        .frame_full (frame_full),
        .frame_out  (frame)
    );

    // Next-state logic. cen_d defaults to zero so the enable is only ever
    // high for the single STROBE cycle, and abort in any busy state always
    // lands in IDLE with cen low.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        config_d = config_q;
        cen_d    = '0;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    blk_d   = '0;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (frame_full) begin
                    state_d  = STROBE;
                    config_d = frame;
                    cen_d    = NUM_BLOCKS'(1) << blk_q;
                end
            end
            STROBE: begin
                state_d = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (blk_q == LAST_BLK) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    blk_d   = blk_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            config_q <= '0;
            cen_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            config_q <= config_d;
            cen_q    <= cen_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Testbench for config_loader: a four-block instance for multi-frame passes,
// backpressure, abort, start corner cases and async reset, and a one-block
// instance for the single-frame case.
// -----------------------------------------------------------------------------
module tb_config_loader;

    logic        cclk;
    logic        rst_n;

    // Four-block instance
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] config_out;
    logic [3:0]  cen;
    logic        busy;
    logic        done;

    // One-block instance
    logic        s_start;
    logic        s_abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_config;
    logic [0:0]  s_cen;
    logic        s_busy;
    logic        s_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int xfer_edge;

    typedef struct {
        logic [15:0] frame;
        logic [3:0]  cen;
    } exp_t;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] frame;
        logic [3:0]  cen;
    } vec_t;

    exp_t sb_q[$];
    exp_t e;
    logic        mon_en = 1'b0;
    logic        pending_hold = 1'b0;
    logic [15:0] hold_frame;

    config_loader #(
        .WORD_BITS  (8),
        .MEM_SIZE   (16),
        .NUM_BLOCKS (4)
    ) dut (
        .cclk       (cclk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .config_out (config_out),
        .cen        (cen),
        .busy       (busy),
        .done       (done)
    );

    config_loader #(
        .WORD_BITS  (8),
        .MEM_SIZE   (16),
        .NUM_BLOCKS (1)
    ) dut1 (
        .cclk       (cclk),
        .rst_n      (rst_n),
        .start      (s_start),
        .abort      (s_abort),
        .in_data    (s_data),
        .in_valid   (s_valid),
        .in_ready   (s_ready),
        .config_out (s_config),
        .cen        (s_cen),
        .busy       (s_busy),
        .done       (s_done)
    );

    // 100 MHz configuration clock
    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Edge counter, used to measure pass length in clock edges
    always @(posedge cclk) cyc <= cyc + 1;

    // Watchdog so a stuck design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one word on the four-block instance and wait (bounded) for it to
    // be accepted. Called at a falling edge; returns at the falling edge
    // after the transfer, leaving in_valid high for back-to-back use.
    task automatic applyStimulus(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge cclk);
            n++;
        end
        if (n >= 50) checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
        @(negedge cclk);
        xfer_edge = cyc;
    endtask

    task automatic waitDone(output int done_edge);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge cclk);
            n++;
        end
        if (n >= 100) checkOutput("done timeout", 32'(done), 32'd1);
        done_edge = cyc;
    endtask

    // Scoreboard monitor: every cen pulse must match the oldest expected
    // frame, and the following (HOLD) cycle must keep the frame with cen low.
    always @(negedge cclk) begin
        if (!mon_en) begin
            pending_hold = 1'b0;
        end else begin
            if (pending_hold) begin
                checkOutput("hold config_out", 32'(config_out), 32'(hold_frame));
                checkOutput("hold cen", 32'(cen), 32'd0);
                pending_hold = 1'b0;
            end
            if (cen != 4'd0) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected cen", 32'(cen), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("strobe cen", 32'(cen), 32'(e.cen));
                    checkOutput("strobe config_out", 32'(config_out), 32'(e.frame));
                    pending_hold = 1'b1;
                    hold_frame   = e.frame;
                end
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   first_edge;
        int   done_edge;

        vecs[0] = '{lo: 8'h01, hi: 8'h02, frame: 16'h0201, cen: 4'b0001};
        vecs[1] = '{lo: 8'h03, hi: 8'h04, frame: 16'h0403, cen: 4'b0010};
        vecs[2] = '{lo: 8'h05, hi: 8'h06, frame: 16'h0605, cen: 4'b0100};
        vecs[3] = '{lo: 8'h07, hi: 8'h08, frame: 16'h0807, cen: 4'b1000};

        start    = 1'b0;
        abort    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        s_start  = 1'b0;
        s_abort  = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        rst_n    = 1'b0;

        // ---- Reset values ----
        repeat (2) @(negedge cclk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset config_out", 32'(config_out), 32'd0);
        checkOutput("reset cen", 32'(cen), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge cclk);

        // ---- Single frame on the one-block instance ----
        s_start = 1'b1;
        @(negedge cclk);
        s_start = 1'b0;
        checkOutput("single ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 8'h34;
        @(negedge cclk);
        s_data  = 8'h12;
        @(negedge cclk);
        s_valid = 1'b0;
        checkOutput("single strobe cen", 32'(s_cen), 32'd1);
        checkOutput("single config_out", 32'(s_config), 32'h1234);
        checkOutput("single ready in strobe", 32'(s_ready), 32'd0);
        @(negedge cclk);
        checkOutput("single hold cen", 32'(s_cen), 32'd0);
        checkOutput("single hold config_out", 32'(s_config), 32'h1234);
        @(negedge cclk);
        checkOutput("single done", 32'(s_done), 32'd1);
        checkOutput("single busy", 32'(s_busy), 32'd0);

        // ---- Full four-block pass, continuous valid ----
        mon_en = 1'b1;
        start  = 1'b1;
        @(negedge cclk);
        start  = 1'b0;
        checkOutput("busy after start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{frame: vecs[i].frame, cen: vecs[i].cen});
            applyStimulus(vecs[i].lo);
            if (i == 0) first_edge = xfer_edge;
            applyStimulus(vecs[i].hi);
        end
        in_valid = 1'b0;
        waitDone(done_edge);
        checkOutput("pass length edges", 32'(done_edge - first_edge + 1), 32'd16);
        checkOutput("pass done", 32'(done), 32'd1);
        checkOutput("pass busy", 32'(busy), 32'd0);
        checkOutput("pass frames consumed", 32'(sb_q.size()), 32'd0);
        @(negedge cclk);
        checkOutput("idle keeps frame", 32'(config_out), 32'h0807);

        // ---- Backpressure gaps, then abort mid frame 2 ----
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        checkOutput("done cleared by start", 32'(done), 32'd0);
        sb_q.push_back('{frame: 16'hB2A1, cen: 4'b0001});
        in_valid = 1'b1;
        in_data  = 8'hA1;
        @(negedge cclk);
        in_valid = 1'b0;
        in_data  = 8'hEE;
        @(negedge cclk);
        @(negedge cclk);
        in_valid = 1'b1;
        in_data  = 8'hB2;
        @(negedge cclk);
        in_valid = 1'b0;
        checkOutput("ready low in STROBE", 32'(in_ready), 32'd0);
        @(negedge cclk);
        checkOutput("ready low in HOLD", 32'(in_ready), 32'd0);
        @(negedge cclk);
        checkOutput("ready back in LOAD", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge cclk);
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge cclk);
        abort    = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort cen", 32'(cen), 32'd0);
        checkOutput("abort config_out", 32'(config_out), 32'hB2A1);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort frames consumed", 32'(sb_q.size()), 32'd0);

        // ---- start+abort together in IDLE, start then held for the pass ----
        start = 1'b1;
        abort = 1'b1;
        @(negedge cclk);
        abort = 1'b0;
        checkOutput("start beats abort", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{frame: {8'h80 + 8'(i), 8'h40 + 8'(i)},
                             cen:   4'b0001 << i});
            applyStimulus(8'h40 + 8'(i));
            applyStimulus(8'h80 + 8'(i));
        end
        in_valid = 1'b0;
        waitDone(done_edge);
        start = 1'b0;
        repeat (3) @(negedge cclk);
        checkOutput("held start single pass busy", 32'(busy), 32'd0);
        checkOutput("held start done", 32'(done), 32'd1);
        checkOutput("held start frames consumed", 32'(sb_q.size()), 32'd0);

        // ---- Asynchronous reset during STROBE ----
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        sb_q.push_back('{frame: 16'h5A3C, cen: 4'b0001});
        applyStimulus(8'h3C);
        applyStimulus(8'h5A);
        in_valid = 1'b0;
        checkOutput("pre-reset cen", 32'(cen), 32'd1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("async reset cen", 32'(cen), 32'd0);
        checkOutput("async reset config_out", 32'(config_out), 32'd0);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd0);
        @(negedge cclk);
        rst_n = 1'b1;
        @(negedge cclk);
        checkOutput("final frames consumed", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
